seq_detect_moore_param: RTL
===========================

Name: seq_detect_moore_param

Overview:
- Parametrised Moore-style serial sequence detector that generalises the fixed 4-bit overlap detector.
- Compile-time pattern and length; run-time overlap / non-overlap mode; sample-enable; saturating match counter; progress output.
- Sits on a 1-bit serial data path. Its outputs feed control logic and status registers.

Parameters:
- PAT_LEN, 4, pattern length in bits; legal range 2..32.
- PATTERN, 4'b1011, pattern value PAT_LEN bits wide; the MSB is the first bit received.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- res  input  1  reset, synchronous, active-high.
- en  input  1  sample enable; a is consumed only on edges where en=1.
- a  input  1  serial data bit.
- overlap  input  1  1 = overlapping detection; 0 = non-overlapping detection.
- cnt_clr  input  1  synchronous clear of match_cnt.
- y  output  1  Moore detect flag; 1 while the FSM is in the MATCH state.
- prog  output  $clog2(PAT_LEN+1)  current state index = number of pattern bits matched (0..PAT_LEN).
- match_cnt  output  CNT_W  number of matches seen since reset/clear; saturates.

Behaviour:
- States: S0..S(PAT_LEN); Sk means the first k pattern bits (MSB-first) are matched. S(PAT_LEN) is MATCH.
- Reset: res=1 at an edge gives state S0, y=0, prog=0, match_cnt=0. This overrides en, cnt_clr and all other inputs, including mid-pattern and while in MATCH.
- en=0: state, y, prog and match_cnt all hold; a is ignored. If the FSM is in MATCH, y stays 1 until the next enabled edge.
- Transition from Sk (k<PAT_LEN) on bit b (full KMP fallback):
  - next state = largest j <= k+1 such that the last j bits of (prefix_k followed by b) equal prefix_j.
  - For 1011 this means: S1 on 1 stays S1; S3 on 0 goes to S2; S2 on 0 goes to S0.
- Transition from MATCH on bit b:
  - overlap=1: next state = largest j <= PAT_LEN such that the last j bits of (PATTERN followed by b) equal prefix_j. For 1011: b=1 gives S1, b=0 gives S2.
  - overlap=0: the history is discarded; next state = S1 if b equals PATTERN[PAT_LEN-1], else S0.
- overlap is sampled only on the edge that leaves MATCH. Changing it at any other time has no effect on the current partial match.
- Output y = (state==MATCH). It is decoded from the state register only, with no combinational path from a.
  - Latency: the final pattern bit is sampled at edge N, so y=1 during the cycle after edge N.
- prog is the registered state index.
- match_cnt:
  - Increments by 1 on every edge that enters MATCH.
  - Saturates at 2^CNT_W-1.
  - cnt_clr=1 forces it to 0 at the edge, even if a match is entered on that same edge (clear wins; that match is not counted). The FSM is unaffected by cnt_clr.
- The transition table is generated from PATTERN at elaboration (function or generate loop). There is no run-time pattern storage.
- Illegal or unreachable state encodings go to S0 on the next enabled edge.

Test Plan:
1. Default params, overlap=1, en=1, a stream 1,0,1,1,0,1,1 -> y=1 in the cycles after bit 4 and bit 7 only; prog after bit 5 = 2; match_cnt=2.
2. Same stream with overlap=0 -> y=1 only after bit 4; prog after bit 7 = 1; match_cnt=1.
3. PAT_LEN=3, PATTERN=3'b111, stream of six 1s -> overlap=1 gives y high after bits 3,4,5,6 and match_cnt=4; overlap=0 gives y after bits 3 and 6 and match_cnt=2.
4. Default params, stream 1,0,1 with en=0 inserted for 3 cycles between each bit, then 1 -> prog holds during gaps; y=1 one cycle after the final enabled edge and stays 1 through a following en=0 window; match_cnt=1.
5. CNT_W=2, overlap=1, stream 1011 repeated 5 times back-to-back -> match_cnt = 1,2,3,3,3; assert cnt_clr on the edge of the 6th match entry -> match_cnt=0, y=1.
6. res=1 asserted after 1,0,1 (prog=3) and again while in MATCH -> next cycle prog=0, y=0, match_cnt=0; then bit 1 gives prog=1, showing no stale history.

Source files
------------

// File: rtl/seq_detect_moore_param_if.sv
// Serial-detector bus: sample strobe, data bit and controls in; detect flag, progress and match count out.
// The parameters must match those of the detector instance bound to this interface.
interface seq_detect_moore_param_if #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);
    localparam int PW = $clog2(PAT_LEN + 1);

    logic             en;
    logic             a;
    logic             overlap;
    logic             cnt_clr;
    logic             y;
    logic [PW-1:0]    prog;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output en, a, overlap, cnt_clr,
        input  y, prog, match_cnt
    );

    modport slave (
        input  en, a, overlap, cnt_clr,
        output y, prog, match_cnt
    );
endinterface

// File: rtl/seq_detect_moore_param.sv
// Parametrised Moore sequence detector. The next-state table is derived from PATTERN at
// elaboration using prefix/suffix (KMP) fallback. It also provides a saturating match counter.
module seq_detect_moore_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  res,
    seq_detect_moore_param_if.slave bus
);
    localparam int               PW       = $clog2(PAT_LEN + 1);
    localparam int               N_ENT    = 2 * (PAT_LEN + 1);
    localparam logic [PW-1:0]    MATCH_ST = PW'(PAT_LEN);
    localparam logic [PW-1:0]    S0_ST    = {PW{1'b0}};
    localparam logic [PW-1:0]    S1_ST    = PW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef logic [N_ENT-1:0][PW-1:0] tbl_t;

    // Longest prefix of PATTERN that is a suffix of (first k pattern bits, then b).
    function automatic int kmp_next(input int k, input logic b);
        int   best;
        int   idx;
        logic ok;
        logic sb;
        best = 0;
        for (int j = 1; j <= PAT_LEN; j++) begin
            ok = (j <= k + 1);
            for (int m = 0; m < j; m++) begin
                idx = k + 1 - j + m;
                sb  = (idx >= 0 && idx < k) ? PATTERN[PAT_LEN-1-idx] : b;
                ok  = ok & (sb == PATTERN[PAT_LEN-1-m]);
            end
            best = ok ? j : best;
        end
        return best;
    endfunction

    function automatic tbl_t build_tbl();
        tbl_t t;
        for (int k = 0; k <= PAT_LEN; k++) begin
            t[2*k]   = PW'(kmp_next(k, 1'b0));
            t[2*k+1] = PW'(kmp_next(k, 1'b1));
        end
        return t;
    endfunction

    localparam tbl_t NXT_TBL = build_tbl();

    logic [PW-1:0]    state_q;
    logic [PW-1:0]    state_d;
    logic             y_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             enter_match_s;

    // Next state and counter; the table entry for MATCH is the overlapping fallback.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        enter_match_s = 1'b0;
        if (bus.en) begin
            if (state_q > MATCH_ST) begin
                state_d = S0_ST;
            end else if ((state_q == MATCH_ST) && !bus.overlap) begin
                state_d = (bus.a == PATTERN[PAT_LEN-1]) ? S1_ST : S0_ST;
            end else begin
                state_d = NXT_TBL[{state_q, bus.a}];
            end
            enter_match_s = (state_d == MATCH_ST);
        end else begin
            state_d = state_q;
        end
        if (bus.cnt_clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (enter_match_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, detect flag and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= S0_ST;
            y_q     <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            y_q     <= (state_d == MATCH_ST);
            cnt_q   <= cnt_d;
        end
    end

    assign bus.y         = y_q;
    assign bus.prog      = state_q;
    assign bus.match_cnt = cnt_q;
endmodule
